// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx write port among N_REQ byte-stream
// requesters. Round-robin arbitration happens at packet granularity, so the
// bytes of two packets never interleave on the UART. An optional idle timeout
// releases a lock whose owner has stopped requesting.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   req_wreq       per-requester write request
//   req_wlast      per-requester last-word flag (qualified by req_wreq)
//   req_wdata      per-requester data, requester i at [i*BYTE_WIDTH*8 +: BYTE_WIDTH*8]
//   req_wgnt       per-requester accept (combinational from i_wgnt)
//   o_wreq         write request to uart_tx (combinational)
//   i_wgnt         write grant from uart_tx
//   o_wdata        write data to uart_tx (combinational)
//   owner_valid    a requester holds the lock
//   owner_id       current or most recent owner index
//   timeout_pulse  one-cycle strobe when a lock is force-released
module uart_tx_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned BYTE_WIDTH     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned ID_W           = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_wreq,
  input  logic [N_REQ-1:0]              req_wlast,
  input  logic [N_REQ*BYTE_WIDTH*8-1:0] req_wdata,
  output logic [N_REQ-1:0]              req_wgnt,
  output logic                          o_wreq,
  input  logic                          i_wgnt,
  output logic [BYTE_WIDTH*8-1:0]       o_wdata,
  output logic                          owner_valid,
  output logic [ID_W-1:0]               owner_id,
  output logic                          timeout_pulse
);

  localparam int unsigned DW    = BYTE_WIDTH * 8;
  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  idle_cnt;
  logic              arb_found;
  logic [ID_W-1:0]   arb_id;
  logic [ID_W-1:0]   scan_idx;
  logic              owner_req;
  logic              owner_last;
  logic [DW-1:0]     owner_data;
  logic              xfer_last;
  logic              timeout_hit;

  // Round-robin pick: first pending requester after owner_id, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = owner_id;
    scan_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = ID_W'((32'(owner_id) + k) % N_REQ);
      if (!arb_found && req_wreq[scan_idx]) begin
        arb_found = 1'b1;
        arb_id    = scan_idx;
      end
    end
  end

  // Owner-side request/last/data selection.
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_id == ID_W'(i)) begin
        owner_req  = req_wreq[i];
        owner_last = req_wlast[i];
        owner_data = req_wdata[i*DW +: DW];
      end
    end
  end

  assign xfer_last = (state == LOCKED) && owner_req && i_wgnt && owner_last;

  // Only true owner silence counts; a stalled downstream keeps owner_req high.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == LOCKED) && !owner_req &&
                       ((idle_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arb_found) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer_last || timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: the owner is wired straight through to uart_tx while locked.
  always_comb begin
    o_wreq   = 1'b0;
    o_wdata  = '0;
    req_wgnt = '0;
    if (state == LOCKED) begin
      o_wreq             = owner_req;
      o_wdata            = owner_data;
      req_wgnt[owner_id] = i_wgnt & owner_req;
    end
  end

  // Owner tracking, idle counter and timeout strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_id      <= ID_W'(N_REQ - 1);
      owner_valid   <= 1'b0;
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeout_hit;
      owner_valid   <= (state_nxt == LOCKED);
      if ((state == IDLE) && arb_found) begin
        owner_id <= arb_id;
      end
      if ((TIMEOUT_CYCLES == 0) || (state != LOCKED) || owner_req || timeout_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, BYTE_WIDTH=1, TIMEOUT_CYCLES=20).
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 20;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_wreq;
  logic [N-1:0]   req_wlast;
  logic [N*8-1:0] req_wdata;
  logic [N-1:0]   req_wgnt;
  logic           o_wreq;
  logic           i_wgnt;
  logic [7:0]     o_wdata;
  logic           owner_valid;
  logic [1:0]     owner_id;
  logic           timeout_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] ab[3] = '{8'h41, 8'h42, 8'h0a};

  uart_tx_arbiter #(
    .N_REQ(N), .BYTE_WIDTH(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_wreq(req_wreq), .req_wlast(req_wlast), .req_wdata(req_wdata),
    .req_wgnt(req_wgnt), .o_wreq(o_wreq), .i_wgnt(i_wgnt), .o_wdata(o_wdata),
    .owner_valid(owner_valid), .owner_id(owner_id), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // UART-side sink: every accepted byte, in order.
  always @(posedge clk) if (rst_n && o_wreq && i_wgnt) log_q.push_back(o_wdata);
  always @(posedge clk) if (timeout_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] b);
    req_wdata[i*8 +: 8] = b;
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) chk(tag, log_q[i], exp_q[i]);
    log_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, owner_valid, 1'b0);
    chk({tag, "_id"}, owner_id, 2'd3);
    chk({tag, "_wreq"}, o_wreq, 1'b0);
    chk({tag, "_wdata"}, o_wdata, 8'h00);
    chk({tag, "_wgnt"}, req_wgnt, 4'b0000);
    chk({tag, "_pulse"}, timeout_pulse, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    logic [3:0] gsum;
    rst_n = 1'b0; req_wreq = '0; req_wlast = '0; req_wdata = '0; i_wgnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");

    // Requester 0 wins first; requester 2 waits for 0's wlast.
    rst_n = 1'b1;
    req_wreq = 4'b0101; set_data(0, 8'h41); set_data(2, 8'h99);
    #1;
    chk("t1_arb_valid", owner_valid, 1'b0);
    chk("t1_arb_wgnt", req_wgnt, 4'b0000);
    tick();
    chk("t1_id", owner_id, 2'd0);
    chk("t1_valid", owner_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_data(0, ab[i]); req_wlast[0] = (i == 2);
      #1;
      chk("t1_data", o_wdata, ab[i]);
      chk("t1_gnt", req_wgnt, 4'b0001);
      tick();
    end
    req_wreq = 4'b0100; req_wlast = '0;
    #1;
    chk("t1_gap_valid", owner_valid, 1'b0);
    chk("t1_gap_wreq", o_wreq, 1'b0);
    chk("t1_gap_id", owner_id, 2'd0);
    tick();
    chk("t1_id2", owner_id, 2'd2);
    chk("t1_gnt2", req_wgnt, 4'b0100);
    chk("t1_data2", o_wdata, 8'h99);
    req_wlast[2] = 1'b1;
    tick();
    req_wreq = '0; req_wlast = '0;
    tick();
    exp_q = '{8'h41, 8'h42, 8'h0a, 8'h99};
    chk_log("t1_log");

    // "AB\n" from 0 while 1 requests continuously; pointer at 2 so 0 wins.
    req_wreq = 4'b0011; set_data(1, 8'h31);
    tick();
    chk("t2_id", owner_id, 2'd0);
    for (int i = 0; i < 3; i++) begin
      set_data(0, ab[i]); req_wlast[0] = (i == 2);
      #1;
      chk("t2_data", o_wdata, ab[i]);
      chk("t2_gnt", req_wgnt, 4'b0001);
      tick();
    end
    req_wreq = 4'b0010; req_wlast = '0;
    #1;
    chk("t2_gap_wreq", o_wreq, 1'b0);
    tick();
    chk("t2_id1", owner_id, 2'd1);
    chk("t2_data1", o_wdata, 8'h31);
    req_wlast[1] = 1'b1;
    tick();
    req_wreq = '0; req_wlast = '0;
    tick();
    exp_q = '{8'h41, 8'h42, 8'h0a, 8'h31};
    chk_log("t2_log");

    // Asynchronous reset mid-packet of requester 1.
    req_wreq = 4'b0010; set_data(1, 8'h81);
    tick();
    chk("t6_id", owner_id, 2'd1);
    tick();
    req_wreq = 4'b0011; set_data(1, 8'h82);
    #1;
    chk("t6_gnt", req_wgnt, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    // All four hold single-word packets: order 0,1,2,3,0,1.
    req_wreq = 4'b1111; req_wlast = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 8'(8'h30 + i));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (k % 4);
      #1;
      chk("t3_gap_wreq", o_wreq, 1'b0);
      tick();
      chk("t3_id", owner_id, 32'(k % 4));
      chk("t3_gnt", req_wgnt, eg);
      tick();
    end
    req_wreq = '0; req_wlast = '0;
    tick();
    exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30, 8'h31};
    chk_log("t3_log");

    // 50-cycle downstream stall with owner still requesting: no timeout.
    req_wreq = 4'b1000; set_data(3, 8'h51);
    tick();
    chk("t4_id", owner_id, 2'd3);
    tick();
    set_data(3, 8'h52); i_wgnt = 1'b0;
    p0 = pulse_cnt; gsum = '0;
    repeat (50) begin
      tick();
      gsum |= req_wgnt;
    end
    chk("t4_valid", owner_valid, 1'b1);
    chk("t4_pulses", 32'(pulse_cnt - p0), 0);
    chk("t4_gsum", gsum, 4'b0000);
    i_wgnt = 1'b1; req_wlast[3] = 1'b1;
    #1;
    chk("t4_gnt", req_wgnt, 4'b1000);
    chk("t4_data", o_wdata, 8'h52);
    tick();
    req_wreq = '0; req_wlast = '0;
    tick();
    exp_q = '{8'h51, 8'h52};
    chk_log("t4_log");

    // Owner 2 goes silent after one byte; released after 20 idle cycles.
    req_wreq = 4'b1100; set_data(2, 8'h61); set_data(3, 8'h71);
    tick();
    chk("t5_id", owner_id, 2'd2);
    tick();
    req_wreq = 4'b1000;
    n = 0; gsum = '0;
    do begin
      tick();
      n++;
      gsum |= req_wgnt;
    end while (!timeout_pulse && n < 40);
    chk("t5_cycles", 32'(n), 32'(TO));
    chk("t5_valid", owner_valid, 1'b0);
    chk("t5_wreq", o_wreq, 1'b0);
    chk("t5_gsum", gsum, 4'b0000);
    tick();
    chk("t5_pulse_off", timeout_pulse, 1'b0);
    chk("t5_id3", owner_id, 2'd3);
    chk("t5_gnt3", req_wgnt, 4'b1000);
    chk("t5_data3", o_wdata, 8'h71);
    req_wlast[3] = 1'b1;
    tick();
    req_wreq = '0; req_wlast = '0;
    tick();
    exp_q = '{8'h61, 8'h71};
    chk_log("t5_log");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
